obi_wrr_arbiter: RTL
====================

# obi_wrr_arbiter

Weighted round-robin arbiter that shares one OBI subordinate port among `NumMgr` OBI managers, for example several managers in front of a single memory or a single crossbar subordinate port. It holds the address phase stable until the subordinate grants it. It records the owner of every granted transaction in an in-order FIFO and routes each response back to its owner. It also bounds the number of outstanding transactions and flags responses that arrive with no matching request. Both sides run OBI with `CombGnt=0` and `UseRReady=0`; the subordinate returns responses in order.

## Interface
Parameters:
- `NumMgr`, default 4: number of manager ports. Must be at least 2.
- `AddrWidth`, default 32: address width.
- `DataWidth`, default 32: data width. Byte-enable width is `DataWidth/8`.
- `IdWidth`, default 5: width of `aid`/`rid`. IDs pass through unmodified.
- `MaxTrans`, default 8: maximum outstanding transactions. Also the FIFO depth. Must be at least 1.
- `WeightWidth`, default 4: width of each per-manager weight.

Ports (reset `rst_n`, asynchronous, active-high; clock `clk`):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-high.
- `weight_i`, in, `NumMgr*WeightWidth`: per-manager weight. Manager k may take `weight_i[k]+1` consecutive grants.
- `mgr_req_i`, in, `NumMgr`: request from each manager.
- `mgr_gnt_o`, out, `NumMgr`: grant to each manager.
- `mgr_addr_i`, in, `NumMgr*AddrWidth`: A-channel address, one slice per manager.
- `mgr_we_i`, in, `NumMgr`: write enable, one bit per manager.
- `mgr_be_i`, in, `NumMgr*DataWidth/8`: byte enables, one slice per manager.
- `mgr_wdata_i`, in, `NumMgr*DataWidth`: write data, one slice per manager.
- `mgr_aid_i`, in, `NumMgr*IdWidth`: transaction ID, one slice per manager.
- `mgr_rvalid_o`, out, `NumMgr`: response valid, routed to the owning manager only.
- `mgr_rdata_o`, out, `DataWidth`: response data, broadcast to all managers.
- `mgr_rid_o`, out, `IdWidth`: response ID, broadcast to all managers.
- `mgr_err_o`, out, 1: response error, broadcast to all managers.
- `sbr_req_o`, out, 1: request to the subordinate.
- `sbr_gnt_i`, in, 1: grant from the subordinate.
- `sbr_addr_o`, out, `AddrWidth`: muxed address from the selected manager.
- `sbr_we_o`, out, 1: muxed write enable.
- `sbr_be_o`, out, `DataWidth/8`: muxed byte enables.
- `sbr_wdata_o`, out, `DataWidth`: muxed write data.
- `sbr_aid_o`, out, `IdWidth`: muxed transaction ID.
- `sbr_rvalid_i`, in, 1: response valid from the subordinate.
- `sbr_rdata_i`, in, `DataWidth`: response data.
- `sbr_rid_i`, in, `IdWidth`: response ID.
- `sbr_err_i`, in, 1: response error.
- `outstanding_o`, out, `$clog2(MaxTrans+1)`: current FIFO occupancy.
- `unexp_rsp_o`, out, 1: sticky flag. Set when a response arrives while the FIFO is empty.

## Operation
- **State registers:**
  - `ptr_q`: round-robin pointer.
  - `credit_q`: grants already taken by the current holder.
  - `lock_q` and `sel_q`: address-phase lock and its held selection.
  - Owner FIFO: depth `MaxTrans`, entries `$clog2(NumMgr)` bits wide.
  - `cnt_q`: FIFO occupancy.
  - `unexp_q`: sticky unexpected-response flag.
- **Selection, when `lock_q`=0:**
  - If `mgr_req_i[ptr_q]`=1 and `credit_q <= weight_i[ptr_q]`, the winner is `ptr_q`.
  - Otherwise the winner is the first requesting index scanning `ptr_q+1`, `ptr_q+2`, … (mod `NumMgr`).
- **Selection, when `lock_q`=1:** the winner is `sel_q`. The A-channel mux must not change while a request is ungranted.
- **Subordinate request:** `sbr_req_o = |mgr_req_i & (cnt_q != MaxTrans)`. The `sbr_addr_o`/`sbr_we_o`/`sbr_be_o`/`sbr_wdata_o`/`sbr_aid_o` outputs carry the winner's fields.
- **Manager grant:** `mgr_gnt_o[w] = sbr_req_o & sbr_gnt_i`, where w is the winner. All other grant bits are 0.
- **Lock:**
  - `sbr_req_o & ~sbr_gnt_i` sets `lock_q` and loads `sel_q` with the winner.
  - A handshake (`sbr_req_o & sbr_gnt_i`) clears `lock_q`.
- **Credit update on a handshake:**
  - If the winner equals `ptr_q` and `credit_q < weight_i[ptr_q]`: `credit_q` increments and `ptr_q` holds.
  - If the winner equals `ptr_q` and its credit is exhausted: `ptr_q` becomes winner+1 (mod `NumMgr`) and `credit_q` becomes 0.
  - If the winner differs from `ptr_q`: `ptr_q` becomes the winner and `credit_q` becomes 1. If `weight_i[winner]` is 0, the pointer instead advances immediately to winner+1 and `credit_q` becomes 0.
- **FIFO:**
  - Push the winner index on every handshake.
  - Pop on `sbr_rvalid_i` when `cnt_q` > 0.
  - Push and pop in the same cycle leave `cnt_q` unchanged.
  - Pointers wrap modulo `MaxTrans`.
- **Response routing:**
  - `mgr_rvalid_o[head] = sbr_rvalid_i & (cnt_q != 0)`.
  - `rdata`, `rid` and `err` pass through combinationally.
- **Unexpected response:**
  - `sbr_rvalid_i` with `cnt_q`=0 is dropped. No `mgr_rvalid_o` bit is set, and `unexp_q` is set.
  - `unexp_q` clears only on reset.

## Timing
- **Reset:** while `rst_n`=1, all registers are 0, `mgr_gnt_o`=0, `mgr_rvalid_o`=0, `sbr_req_o`=0, `outstanding_o`=0 and `unexp_rsp_o`=0. Reset mid-transaction discards all FIFO contents.
- **Address path:** zero-cycle request and grant path. `sbr_req_o` and `mgr_gnt_o` are combinational from the inputs and the registered state.
- **Response path:** zero-cycle latency. `mgr_rvalid_o` is asserted in the same cycle as `sbr_rvalid_i`.
- **Earliest response:** one cycle after the handshake. A push in cycle t is visible as the head in cycle t+1.
- **Full FIFO:** when `cnt_q` = `MaxTrans`, `sbr_req_o`=0 even if a pop happens in the same cycle. Issue resumes the cycle after `cnt_q` drops.
- **Throughput:** one grant per cycle when the subordinate grants continuously and the FIFO is not full.

## Test plan
- **Lock stability:** `NumMgr`=4, all weights 0. Manager 2 alone requests at address 0x100 with `sbr_gnt_i` low for 3 cycles, while manager 0 starts requesting in cycle 2 → `sbr_addr_o`=0x100 stable for all 3 cycles, then `mgr_gnt_o`=4'b0100.
- **Weighted round-robin:** weights {3,0,1,0}, all four managers requesting, `sbr_gnt_i`=1 → grant order 0,0,0,0,1,2,2,3,0,0,0,0.
- **Full FIFO back-pressure:** `MaxTrans`=2, no responses, continuous requests → exactly 2 handshakes, then `sbr_req_o`=0 and `outstanding_o`=2. One `sbr_rvalid_i` → `sbr_req_o`=1 from the next cycle.
- **Response routing:** grants to managers 1,3,1 followed by 3 responses with `rdata` 0xA, 0xB, 0xC → `mgr_rvalid_o` = 0010, 1000, 0010 respectively, with matching `mgr_rdata_o`.
- **Unexpected response:** `sbr_rvalid_i`=1 with an empty FIFO → `mgr_rvalid_o`=0 and `unexp_rsp_o`=1, held until reset.
- **Reset mid-operation:** `rst_n` asserted with 3 outstanding transactions → `outstanding_o`=0 and all outputs 0. After release, a fresh grant goes to the lowest requesting index starting from 0.

Source files
------------

// File: rtl/obi_wrr_arbiter.sv
// obi_wrr_arbiter
// Weighted round-robin arbiter that shares one OBI subordinate port among
// NumMgr OBI managers (CombGnt=0, UseRReady=0, in-order responses).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-high reset
//   weight_i         per-manager weight; manager k may take weight+1 grants in a row
//   mgr_*_i/_o       manager-side A channel (req/gnt/addr/we/be/wdata/aid) and
//                    R channel (rvalid per manager, rdata/rid/err broadcast)
//   sbr_*_o/_i       subordinate-side A channel and R channel
//   outstanding_o    owner FIFO occupancy
//   unexp_rsp_o      sticky flag: a response arrived with nothing outstanding
module obi_wrr_arbiter #(
    parameter int NumMgr      = 4,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int IdWidth     = 5,
    parameter int MaxTrans    = 8,
    parameter int WeightWidth = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumMgr*WeightWidth-1:0] weight_i,
    input  logic [NumMgr-1:0]             mgr_req_i,
    output logic [NumMgr-1:0]             mgr_gnt_o,
    input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
    input  logic [NumMgr-1:0]             mgr_we_i,
    input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
    input  logic [NumMgr*IdWidth-1:0]     mgr_aid_i,
    output logic [NumMgr-1:0]             mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic [IdWidth-1:0]            mgr_rid_o,
    output logic                          mgr_err_o,
    output logic                          sbr_req_o,
    input  logic                          sbr_gnt_i,
    output logic [AddrWidth-1:0]          sbr_addr_o,
    output logic                          sbr_we_o,
    output logic [DataWidth/8-1:0]        sbr_be_o,
    output logic [DataWidth-1:0]          sbr_wdata_o,
    output logic [IdWidth-1:0]            sbr_aid_o,
    input  logic                          sbr_rvalid_i,
    input  logic [DataWidth-1:0]          sbr_rdata_i,
    input  logic [IdWidth-1:0]            sbr_rid_i,
    input  logic                          sbr_err_i,
    output logic [$clog2(MaxTrans+1)-1:0] outstanding_o,
    output logic                          unexp_rsp_o
);

    localparam int BeWidth = DataWidth / 8;
    localparam int IdxW    = $clog2(NumMgr);
    localparam int CntW    = $clog2(MaxTrans + 1);
    localparam int PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    lock_e                  lock_q, lock_d;
    logic [IdxW-1:0]        sel_q, sel_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic [IdxW-1:0]        fifo_q [MaxTrans];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        cnt_q;
    logic                   unexp_q;

    logic [IdxW-1:0]        winner, scan_idx, head;
    logic [WeightWidth-1:0] ptr_weight, win_weight;
    logic                   handshake, pop, fifo_full;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        return (idx == IdxW'(NumMgr - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // Weights of the current pointer holder and of the winner.
    always_comb begin
        ptr_weight = '0;
        win_weight = '0;
        for (int k = 0; k < NumMgr; k++) begin
            if (ptr_q == IdxW'(k)) ptr_weight = weight_i[k*WeightWidth +: WeightWidth];
            if (winner == IdxW'(k)) win_weight = weight_i[k*WeightWidth +: WeightWidth];
        end
    end

    // First requester after the pointer; the scan wraps back onto the
    // pointer itself so a lone requester with spent credit still wins.
    always_comb begin
        int  j;
        logic found;
        j        = 0;
        found    = 1'b0;
        scan_idx = ptr_q;
        for (int i = 1; i <= NumMgr; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NumMgr) j = j - NumMgr;
            if (!found && mgr_req_i[IdxW'(j)]) begin
                found    = 1'b1;
                scan_idx = IdxW'(j);
            end
        end
    end

    always_comb begin
        if (lock_q == LOCKED) begin
            winner = sel_q;
        end else if (mgr_req_i[ptr_q] && (credit_q <= ptr_weight)) begin
            winner = ptr_q;
        end else begin
            winner = scan_idx;
        end
    end

    // Lock FSM: state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lock_q <= UNLOCKED;
            sel_q  <= '0;
        end else begin
            lock_q <= lock_d;
            sel_q  <= sel_d;
        end
    end

    // Lock FSM: an issued but ungranted request freezes the selection.
    always_comb begin
        lock_d = lock_q;
        sel_d  = sel_q;
        if (handshake) begin
            lock_d = UNLOCKED;
        end else if (sbr_req_o) begin
            lock_d = LOCKED;
            sel_d  = winner;
        end
    end

    // Lock FSM outputs: request/grant and the A-channel mux. Reset gates the
    // request so nothing is issued while the block is held in reset.
    always_comb begin
        fifo_full   = (cnt_q == CntW'(MaxTrans));
        sbr_req_o   = (|mgr_req_i) & ~fifo_full & ~rst_n;
        handshake   = sbr_req_o & sbr_gnt_i;
        mgr_gnt_o   = '0;
        sbr_addr_o  = '0;
        sbr_we_o    = 1'b0;
        sbr_be_o    = '0;
        sbr_wdata_o = '0;
        sbr_aid_o   = '0;
        for (int k = 0; k < NumMgr; k++) begin
            if (winner == IdxW'(k)) begin
                mgr_gnt_o[k] = handshake;
                sbr_addr_o   = mgr_addr_i[k*AddrWidth +: AddrWidth];
                sbr_we_o     = mgr_we_i[k];
                sbr_be_o     = mgr_be_i[k*BeWidth +: BeWidth];
                sbr_wdata_o  = mgr_wdata_i[k*DataWidth +: DataWidth];
                sbr_aid_o    = mgr_aid_i[k*IdWidth +: IdWidth];
            end
        end
    end

    // Credit bookkeeping. A zero-weight newcomer uses its single grant at
    // once, so the pointer moves past it straight away.
    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (handshake) begin
            if (winner == ptr_q) begin
                if (credit_q < ptr_weight) begin
                    credit_d = credit_q + 1'b1;
                end else begin
                    ptr_d    = next_idx(winner);
                    credit_d = '0;
                end
            end else if (win_weight == '0) begin
                ptr_d    = next_idx(winner);
                credit_d = '0;
            end else begin
                ptr_d    = winner;
                credit_d = WeightWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    // Owner FIFO and response routing.
    always_comb begin
        head         = fifo_q[rd_ptr_q];
        pop          = sbr_rvalid_i & (cnt_q != '0);
        mgr_rvalid_o = '0;
        for (int k = 0; k < NumMgr; k++) begin
            mgr_rvalid_o[k] = pop & (head == IdxW'(k));
        end
        mgr_rdata_o   = sbr_rdata_i;
        mgr_rid_o     = sbr_rid_i;
        mgr_err_o     = sbr_err_i;
        outstanding_o = cnt_q;
        unexp_rsp_o   = unexp_q;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < MaxTrans; k++) fifo_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            unexp_q  <= 1'b0;
        end else begin
            if (handshake) begin
                fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (handshake && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!handshake && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (sbr_rvalid_i && (cnt_q == '0)) unexp_q <= 1'b1;
        end
    end

endmodule
